// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, DR select and opcode helpers shared by the TAP controller.
package jtag_pkg;
   typedef enum logic [3:0] {
      TEST_LOGIC_RESET = 4'h0, RUN_TEST_IDLE = 4'h1,
      SELECT_DR = 4'h2, CAPTURE_DR = 4'h3, SHIFT_DR = 4'h4, EXIT1_DR = 4'h5,
      PAUSE_DR = 4'h6, EXIT2_DR = 4'h7, UPDATE_DR = 4'h8,
      SELECT_IR = 4'h9, CAPTURE_IR = 4'hA, SHIFT_IR = 4'hB, EXIT1_IR = 4'hC,
      PAUSE_IR = 4'hD, EXIT2_IR = 4'hE, UPDATE_IR = 4'hF
   } tap_state_t;
   typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_USER} dr_sel_t;
   function automatic logic [31:0] bypass_opcode(input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < w && i < 32; i++) r[i] = 1'b1;
      return r;
   endfunction
endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: bare IEEE 1149.1 TAP state register and next-state logic.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       clk,
   input  logic       TRST_n,
   input  logic       TMS,
   output tap_state_t state
);
   tap_state_t next;
   always_comb begin
      next = TEST_LOGIC_RESET;
      case (state)
         TEST_LOGIC_RESET: next = TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    next = TMS ? SELECT_DR : RUN_TEST_IDLE;
         SELECT_DR:        next = TMS ? SELECT_IR : CAPTURE_DR;
         CAPTURE_DR:       next = TMS ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR:         next = TMS ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR:         next = TMS ? UPDATE_DR : PAUSE_DR;
         PAUSE_DR:         next = TMS ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR:         next = TMS ? UPDATE_DR : SHIFT_DR;
         UPDATE_DR:        next = TMS ? SELECT_DR : RUN_TEST_IDLE;
         SELECT_IR:        next = TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       next = TMS ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR:         next = TMS ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR:         next = TMS ? UPDATE_IR : PAUSE_IR;
         PAUSE_IR:         next = TMS ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR:         next = TMS ? UPDATE_IR : SHIFT_IR;
         UPDATE_IR:        next = TMS ? SELECT_DR : RUN_TEST_IDLE;
         default:          next = TEST_LOGIC_RESET;
      endcase
   end
   always_ff @(posedge clk or negedge TRST_n)
      if (!TRST_n) state <= TEST_LOGIC_RESET;
      else state <= next;
endmodule

// File: rtl/jtag_tap_core.sv
// jtag_tap_core: TAP controller with instruction register, BYPASS/IDCODE/user data
// registers and capture/update strobes toward core logic.
module jtag_tap_core
   import jtag_pkg::*;
#(
   parameter int          IR_W        = 4,
   parameter int          USER_W      = 8,
   parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001,
   parameter int          INST_IDCODE = 1,
   parameter int          INST_USER   = 2
) (
   input  logic              clk,
   input  logic              TRST_n,
   input  logic              TMS,
   input  logic              TDI,
   output logic              TDO,
   output logic              tdo_en,
   output logic [3:0]        state_obs,
   output logic [IR_W-1:0]   ir_out,
   input  logic [USER_W-1:0] user_dr_in,
   output logic [USER_W-1:0] user_dr_out,
   output logic              user_capture,
   output logic              user_update
);
   localparam logic [IR_W-1:0] IDC = IR_W'(INST_IDCODE);
   localparam logic [IR_W-1:0] USR = IR_W'(INST_USER);
   localparam logic [IR_W-1:0] BYP = IR_W'(bypass_opcode(IR_W));
   tap_state_t state;
   dr_sel_t dr_sel;
   logic [IR_W-1:0] ir, ir_shift;
   logic bypass;
   logic [31:0] idcode_sr;
   logic [USER_W-1:0] user_sr;
   logic [USER_W:0] user_next;
   jtag_tap_fsm u_fsm (.clk(clk), .TRST_n(TRST_n), .TMS(TMS), .state(state));
   // The instruction reads as IDCODE for the whole stay in Test_Logic_Reset, not one edge later.
   assign ir_out = (state == TEST_LOGIC_RESET) ? IDC : ir;
   assign dr_sel = (ir_out == BYP) ? DR_BYPASS :
                   (ir_out == IDC) ? DR_IDCODE :
                   (ir_out == USR) ? DR_USER : DR_BYPASS;
   assign user_next = {TDI, user_sr};
   assign state_obs = state;
   assign tdo_en = (state == SHIFT_DR) || (state == SHIFT_IR);
   assign TDO = (state == SHIFT_IR) ? ir_shift[0] :
                (state != SHIFT_DR) ? 1'b0 :
                (dr_sel == DR_IDCODE) ? idcode_sr[0] :
                (dr_sel == DR_USER) ? user_sr[0] : bypass;
   assign user_capture = (state == CAPTURE_DR) && (dr_sel == DR_USER);
   assign user_update = (state == UPDATE_DR) && (dr_sel == DR_USER);
   always_ff @(posedge clk or negedge TRST_n)
      if (!TRST_n) begin
         ir       <= IDC;
         ir_shift <= '0;
      end else begin
         if (state == TEST_LOGIC_RESET) ir <= IDC;
         if (state == UPDATE_IR) ir <= ir_shift;
         if (state == CAPTURE_IR) ir_shift <= IR_W'(2'b01);
         if (state == SHIFT_IR) ir_shift <= {TDI, ir_shift[IR_W-1:1]};
      end
   always_ff @(posedge clk or negedge TRST_n)
      if (!TRST_n) begin
         bypass      <= 1'b0;
         idcode_sr   <= '0;
         user_sr     <= '0;
         user_dr_out <= '0;
      end else begin
         if (state == CAPTURE_DR) begin
            if (dr_sel == DR_BYPASS) bypass <= 1'b0;
            if (dr_sel == DR_IDCODE) idcode_sr <= IDCODE_VAL;
            if (user_capture) user_sr <= user_dr_in;
         end
         if (state == SHIFT_DR) begin
            if (dr_sel == DR_BYPASS) bypass <= TDI;
            if (dr_sel == DR_IDCODE) idcode_sr <= {TDI, idcode_sr[31:1]};
            if (dr_sel == DR_USER) user_sr <= user_next[USER_W:1];
         end
         if (user_update) user_dr_out <= user_sr;
      end
endmodule

// File: tb/tb_jtag_tap_core.sv
// tb_jtag_tap_core: directed test-plan sequences plus random TMS/TDI traffic,
// all checked against a transaction-level model of the TAP.
module tb_jtag_tap_core;
   logic clk = 0, TRST_n = 0, TMS = 1, TDI = 0;
   logic TDO, tdo_en, user_capture, user_update;
   logic [3:0] state_obs, ir_out;
   logic [7:0] user_dr_in = 0, user_dr_out;
   int checks = 0, failures = 0, cap_cnt = 0, upd_cnt = 0;
   int nxt [16][2];
   int m_state;
   logic [3:0] m_ir, m_irs;
   logic m_byp;
   logic [31:0] m_id;
   logic [7:0] m_usr, m_uout;

   jtag_tap_core dut (
      .clk(clk), .TRST_n(TRST_n), .TMS(TMS), .TDI(TDI), .TDO(TDO), .tdo_en(tdo_en),
      .state_obs(state_obs), .ir_out(ir_out), .user_dr_in(user_dr_in),
      .user_dr_out(user_dr_out), .user_capture(user_capture), .user_update(user_update)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] m_ir_out();
      return (m_state == 0) ? 4'd1 : m_ir;
   endfunction

   // 0 bypass, 1 idcode, 2 user
   function automatic int m_sel();
      return (m_ir_out() == 4'd1) ? 1 : (m_ir_out() == 4'd2) ? 2 : 0;
   endfunction

   function automatic logic m_tdo();
      if (m_state == 11) return m_irs[0];
      if (m_state != 4) return 1'b0;
      return (m_sel() == 1) ? m_id[0] : (m_sel() == 2) ? m_usr[0] : m_byp;
   endfunction

   task automatic model_reset();
      m_state = 0; m_ir = 4'd1; m_irs = 0; m_byp = 0; m_id = 0; m_usr = 0; m_uout = 0;
   endtask

   task automatic model_step(input logic tms_v, input logic tdi_v);
      int s;
      s = m_sel();
      case (m_state)
         0: m_ir = 4'd1;
         3: if (s == 0) m_byp = 0; else if (s == 1) m_id = 32'h1000_0001; else m_usr = user_dr_in;
         4: if (s == 0) m_byp = tdi_v;
            else if (s == 1) m_id = (m_id >> 1) | (32'(tdi_v) << 31);
            else m_usr = (m_usr >> 1) | (8'(tdi_v) << 7);
         8: if (s == 2) m_uout = m_usr;
         10: m_irs = 4'd1;
         11: m_irs = (m_irs >> 1) | (4'(tdi_v) << 3);
         15: m_ir = m_irs;
         default: ;
      endcase
      m_state = nxt[m_state][tms_v];
   endtask

   task automatic compare_all();
      check("state_obs", 32'(state_obs), 32'(m_state));
      check("TDO", 32'(TDO), 32'(m_tdo()));
      check("tdo_en", 32'(tdo_en), 32'(m_state == 4 || m_state == 11));
      check("ir_out", 32'(ir_out), 32'(m_ir_out()));
      check("user_dr_out", 32'(user_dr_out), 32'(m_uout));
      check("user_capture", 32'(user_capture), 32'(m_state == 3 && m_sel() == 2));
      check("user_update", 32'(user_update), 32'(m_state == 8 && m_sel() == 2));
   endtask

   task automatic tick(input logic tms_v, input logic tdi_v, output logic tdo_v);
      TMS = tms_v;
      TDI = tdi_v;
      #0 tdo_v = TDO;
      @(posedge clk);
      model_step(tms_v, tdi_v);
      #1;
      if (user_capture) cap_cnt++;
      if (user_update) upd_cnt++;
      compare_all();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 TRST_n = 0;
      #2 model_reset();
      compare_all();
      TRST_n = 1;
   endtask

   task automatic go(input logic [7:0] tms_seq, input int n);
      logic d;
      for (int i = 0; i < n; i++) tick(tms_seq[i], 1'b0, d);
   endtask

   // From Run_Test_Idle: scan n bits (LSB first) through the DR or IR, back to Run_Test_Idle.
   task automatic scan(input logic is_ir, input logic [31:0] din, input int n, output logic [31:0] dout);
      logic d;
      dout = 0;
      if (is_ir) go(8'b0011, 4); else go(8'b001, 3);
      for (int i = 0; i < n; i++) begin
         tick(i == n - 1, din[i], d);
         dout[i] = d;
      end
      go(8'b01, 2);
   endtask

   initial begin
      logic [31:0] r;
      logic d;
      int en_cnt;
      nxt = '{'{1,0}, '{1,2}, '{3,9}, '{4,5}, '{4,5}, '{6,8}, '{6,7}, '{4,8},
              '{1,2}, '{10,0}, '{11,12}, '{11,12}, '{13,15}, '{13,14}, '{11,15}, '{1,2}};
      model_reset();
      #1 compare_all();
      do_reset();
      // IDCODE straight after reset
      go(8'b0010, 4);
      r = 0; en_cnt = 0;
      for (int i = 0; i < 32; i++) begin
         if (tdo_en) en_cnt++;
         tick(i == 31, 1'b0, d);
         r[i] = d;
      end
      if (tdo_en) en_cnt++;
      check("idcode_read", r, 32'h1000_0001);
      check("idcode_en_cycles", en_cnt, 32);
      go(8'b01, 2);
      // IR capture pattern and load of all-ones
      scan(1'b1, 32'hF, 4, r);
      check("ir_capture", r, 32'h1);
      check("ir_bypass", 32'(ir_out), 32'hF);
      // BYPASS: one-cycle delay of TDI
      scan(1'b0, 32'h4D, 8, r);
      check("bypass_read", r, 32'h9A);
      // user DR
      scan(1'b1, 32'h2, 4, r);
      user_dr_in = 8'hA5;
      cap_cnt = 0; upd_cnt = 0;
      scan(1'b0, 32'h3C, 8, r);
      check("user_read", r, 32'hA5);
      check("user_dr_out", 32'(user_dr_out), 32'h3C);
      check("user_capture_cnt", cap_cnt, 1);
      check("user_update_cnt", upd_cnt, 1);
      // TMS-driven reset from mid Shift_IR
      go(8'b0011, 4);
      tick(1'b0, 1'b1, d);
      go(8'b11111, 5);
      check("tms_reset_state", 32'(state_obs), 32'h0);
      check("tms_reset_ir", 32'(ir_out), 32'h1);
      // async reset from mid Shift_DR, user register selected
      go(8'b0, 1);
      scan(1'b1, 32'h2, 4, r);
      go(8'b001, 3);
      tick(1'b0, 1'b1, d);
      #2 TRST_n = 0;
      #1 model_reset();
      check("async_state", 32'(state_obs), 32'h0);
      check("async_tdo", 32'(TDO), 32'h0);
      check("async_tdo_en", 32'(tdo_en), 32'h0);
      check("async_user_dr_out", 32'(user_dr_out), 32'h0);
      check("async_ir", 32'(ir_out), 32'h1);
      check("async_strobes", 32'({user_capture, user_update}), 32'h0);
      TRST_n = 1;
      // pause in the middle of an IDCODE shift
      go(8'b0010, 4);
      r = 0;
      for (int i = 0; i < 3; i++) begin
         tick(i == 2, 1'b0, d);
         r[i] = d;
      end
      go(8'b0100000, 7);
      for (int i = 3; i < 32; i++) begin
         tick(i == 31, 1'b0, d);
         r[i] = d;
      end
      check("pause_read", r, 32'h1000_0001);
      go(8'b01, 2);
      // random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            #1 TRST_n = 0;
            #1 model_reset();
            compare_all();
            TRST_n = 1;
         end
         if ($urandom_range(0, 19) == 0) user_dr_in = 8'($urandom);
         tick($urandom_range(0, 3) == 0, 1'($urandom), d);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/jtag_tap_core.md
# jtag_tap_core

Parametrised JTAG TAP controller with instruction and data registers. It is the successor to the bare 16-state TAP state machine. It keeps the same state encoding and `state_obs` debug output, and adds:
- a TDI/TDO serial path;
- an IR_W-bit instruction register;
- BYPASS, IDCODE and a user data register, with capture and update strobes toward core logic.

It sits between the board-level JTAG pins and on-chip debug/test logic.

## Interface
- IR_W, 4: instruction register width, ≥2.
- USER_W, 8: user data register width, ≥1.
- IDCODE_VAL, 32'h1000_0001: IDCODE value; bit 0 must be 1.
- INST_IDCODE, 1: opcode selecting IDCODE, zero-extended to IR_W.
- INST_USER, 2: opcode selecting the user DR, zero-extended to IR_W.
- clk  in  1  TCK; all flops on posedge.
- TRST_n  in  1  asynchronous, active-low reset.
- TMS  in  1  test mode select, sampled on posedge clk.
- TDI  in  1  serial data in, sampled on posedge clk.
- TDO  out  1  serial data out.
- tdo_en  out  1  high in Shift_DR or Shift_IR.
- state_obs  out  4  current TAP state, encoded as below.
- ir_out  out  IR_W  current (updated) instruction.
- user_dr_in  in  USER_W  parallel value captured into the user shift register.
- user_dr_out  out  USER_W  parallel value updated from the user shift register.
- user_capture  out  1  one-cycle strobe; user DR captured.
- user_update  out  1  one-cycle strobe; user_dr_out updated.

## Operation
- **State encoding.** 16 states, 4-bit:
  - Test_Logic_Reset 0, Run_Test_Idle 1.
  - Select_DR 2, Capture_DR 3, Shift_DR 4, Exit1_DR 5, Pause_DR 6, Exit2_DR 7, Update_DR 8.
  - Select_IR 9, Capture_IR A, Shift_IR B, Exit1_IR C, Pause_IR D, Exit2_IR E, Update_IR F.
  - `state_obs` equals the state register directly.
- **Transitions.** Standard IEEE 1149.1 graph. Five consecutive TMS=1 cycles reach Test_Logic_Reset from any state.
- **Instruction register.** ir_shift and ir are each IR_W bits.
  - Capture_IR: ir_shift ← {0…, 2'b01}.
  - Shift_IR: ir_shift ← {TDI, ir_shift[IR_W-1:1]}.
  - Update_IR: ir ← ir_shift.
  - While in Test_Logic_Reset: ir ← INST_IDCODE.
- **DR select.** Decoded from ir:
  - INST_IDCODE → IDCODE (32 bits).
  - INST_USER → USER (USER_W bits).
  - All-ones and every other opcode → BYPASS (1 bit).
- **Capture_DR,** selected register only:
  - bypass ← 0;
  - idcode_sr ← IDCODE_VAL;
  - user_sr ← user_dr_in.
- **Shift_DR.** The selected register shifts right, with TDI entering the MSB. Unselected registers hold.
- **Update_DR** with USER selected: user_dr_out ← user_sr.
- **TDO** (combinational from flops):
  - Shift_IR → ir_shift[0];
  - Shift_DR → selected register [0];
  - otherwise 0.
- **Strobes.**
  - user_capture = (state == Capture_DR) && USER selected.
  - user_update = (state == Update_DR) && USER selected.
  - Each is decoded from registered state, so it lasts exactly one cycle per visit.
- **Values held outside their states.** Pause/Exit states hold all shift registers. ir_out and user_dr_out change only in Update_IR, Update_DR or reset.

## Timing
- **Async reset** (TRST_n=0):
  - state = Test_Logic_Reset, state_obs = 0.
  - ir = INST_IDCODE; ir_shift = 0; bypass = 0; idcode_sr = 0; user_sr = 0; user_dr_out = 0.
  - TDO = 0, tdo_en = 0, user_capture = 0, user_update = 0.
- **Reset release.** The first posedge with TRST_n=1 evaluates TMS. Reset mid-shift discards shift contents; ir reverts to IDCODE.
- **Per-edge action.** Each posedge performs the action of the current state and the transition together. TDO presents bit n during the cycle before the posedge that shifts it out.
- **Latencies.**
  - IR update to ir_out: visible the cycle after the Update_IR posedge.
  - DR select: effective from the next Capture_DR.
- **Shift count.** An N-bit shift needs N cycles in Shift_xR. The last bit is shifted on the edge with TMS=1, which exits to Exit1.
- **Pause.** Shift_DR → Exit1 → Pause → Exit2 → Shift_DR resumes with no bit lost or duplicated.

## Structure
- Package jtag_pkg:
  - tap_state_t enum with the 4-bit encoding above;
  - the BYPASS opcode function (all-ones of IR_W);
  - a DR-select enum {DR_BYPASS, DR_IDCODE, DR_USER}.
- Sub-module jtag_tap_fsm holds the state register and next-state logic only. It exports state, and is reusable by the old observe-only controller.
- The top level holds the IR, the DR registers, the TDO mux and the strobes.

## Test plan
- **IDCODE after reset.** Pulse TRST_n low, then TMS 0,1,0,0 to reach Shift_DR; 32 shifts with TMS=1 on the last. TDO serial LSB-first = 32'h1000_0001; tdo_en=1 for exactly 32 cycles.
- **IR capture and load.** TMS 0,1,1,0,0 reaches Shift_IR. TDO reads 1,0,0,0 while TDI shifts in 4'b1111 (TMS=1 on the 4th). After Update_IR, ir_out = 4'hF.
- **BYPASS.** With ir = 4'hF, shift 8 bits 1,0,1,1,0,0,1,0 through DR. TDO = 0 then the TDI stream delayed by one cycle.
- **User DR.** Load IR = 2 and set user_dr_in = 8'hA5. At Capture_DR, user_capture pulses once. Shift in 8'h3C; TDO yields A5 LSB-first. At Update_DR, user_update pulses and user_dr_out = 8'h3C.
- **Pause mid-shift.** Shift 3 bits of IDCODE, then Exit1 → Pause for 5 cycles → Exit2 → Shift. The remaining 29 bits continue with no gap or repeat; total readout is still 32'h1000_0001.
- **Reset recovery.** Mid-Shift_IR, hold TMS=1 for 5 cycles → state_obs = 0 and ir_out = 1. Separately, assert TRST_n mid-Shift_DR; all outputs reach their reset values immediately, with no clock edge.
